satarx_crc: RTL

//  Receive-side SATA frame CRC checker. Accepts a frame dword stream whose final

---
 rtl/sata_crc_pkg.sv | 27 ++
 rtl/satarx_crc.sv | 97 +++++++++
 2 files changed

// File: rtl/sata_crc_pkg.sv
// Shared SATA frame CRC definitions: default polynomial/seed and the
// dword-at-a-time CRC step used by both the transmit and receive checkers.
package sata_crc_pkg;

   localparam logic [31:0] SATA_POLYNOMIAL  = 32'h04c1_1db7;
   localparam logic [31:0] SATA_INITIAL_CRC = 32'h5232_5032;

   // MSB-first shift of one dword through the CRC register.
   function automatic logic [31:0] advance_crc(
      input logic [31:0] prior,
      input logic [31:0] dword,
      input logic [31:0] poly = SATA_POLYNOMIAL
   );
      logic [31:0] s;
      logic [31:0] d;
      logic        fb;
      s = prior;
      d = dword;
      for (int unsigned k = 0; k < 32; k++) begin
         fb = s[31] ^ d[31];
         s  = {s[30:0], 1'b0} ^ (fb ? poly : '0);
         d  = {d[30:0], 1'b0};
      end
      return s;
   endfunction

endpackage

// File: rtl/satarx_crc.sv
// Receive-side SATA CRC checker: strips the trailing CRC dword from each frame,
// forwards the data and flags the CRC verdict on the last forwarded beat.
module satarx_crc
   import sata_crc_pkg::*;
#(
   parameter logic [31:0] POLYNOMIAL   = SATA_POLYNOMIAL,
   parameter logic [31:0] INITIAL_CRC  = SATA_INITIAL_CRC,
   parameter bit          OPT_LOWPOWER = 1'b1
) (
   input  logic        S_AXI_ACLK,
   input  logic        S_AXI_ARESET,
   input  logic        S_AXIS_TVALID,
   output logic        S_AXIS_TREADY,
   input  logic [31:0] S_AXIS_TDATA,
   input  logic        S_AXIS_TLAST,
   output logic        M_AXIS_TVALID,
   input  logic        M_AXIS_TREADY,
   output logic [31:0] M_AXIS_TDATA,
   output logic        M_AXIS_TLAST,
   output logic        M_AXIS_TUSER,
   output logic        o_crc_err,
   output logic        o_short_frame
);

   typedef enum logic {S_EMPTY, S_HELD} state_t;

   state_t      r_state, w_state_nxt;
   logic [31:0] r_crc, r_held, w_crc_adv;
   logic        r_mvalid, r_mlast, r_muser, r_crc_err, r_short;
   logic [31:0] r_mdata;
   logic        w_sready, w_accept, w_emit, w_short, w_bad, w_frame_err;

   assign w_sready  = !r_mvalid || M_AXIS_TREADY;
   assign w_accept  = S_AXIS_TVALID && w_sready;
   assign w_crc_adv = advance_crc(r_crc, r_held, POLYNOMIAL);

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) r_state <= S_EMPTY;
      else              r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_accept) w_state_nxt = S_AXIS_TLAST ? S_EMPTY : S_HELD;
   end

   always_comb begin
      w_emit      = w_accept && (r_state == S_HELD);
      w_short     = w_accept && (r_state == S_EMPTY) && S_AXIS_TLAST;
      w_bad       = (w_crc_adv != S_AXIS_TDATA);
      w_frame_err = w_emit && S_AXIS_TLAST && w_bad;
   end

   always_ff @(posedge S_AXI_ACLK) begin
      if (S_AXI_ARESET) begin
         r_crc     <= INITIAL_CRC;
         r_held    <= '0;
         r_mvalid  <= 1'b0;
         r_mdata   <= '0;
         r_mlast   <= 1'b0;
         r_muser   <= 1'b0;
         r_crc_err <= 1'b0;
         r_short   <= 1'b0;
      end else begin
         r_crc_err <= w_frame_err || w_short;
         r_short   <= w_short;
         if (w_accept) begin
            // The CRC only absorbs a dword once it is known to be data, not CRC.
            if (S_AXIS_TLAST)            r_crc <= INITIAL_CRC;
            else if (r_state == S_HELD)  r_crc <= w_crc_adv;
            if (!S_AXIS_TLAST)           r_held <= S_AXIS_TDATA;
         end
         if (w_emit) begin
            r_mvalid <= 1'b1;
            r_mdata  <= r_held;
            r_mlast  <= S_AXIS_TLAST;
            r_muser  <= S_AXIS_TLAST && w_bad;
         end else if (M_AXIS_TREADY) begin
            r_mvalid <= 1'b0;
            if (OPT_LOWPOWER) begin
               r_mdata <= '0;
               r_mlast <= 1'b0;
               r_muser <= 1'b0;
            end
         end
      end
   end

   assign S_AXIS_TREADY = w_sready;
   assign M_AXIS_TVALID = r_mvalid;
   assign M_AXIS_TDATA  = r_mdata;
   assign M_AXIS_TLAST  = r_mlast;
   assign M_AXIS_TUSER  = r_muser;
   assign o_crc_err     = r_crc_err;
   assign o_short_frame = r_short;

endmodule
